// File: rtl/countdown_pkg.sv
// countdown_pkg: shared FSM encoding and BCD digit limits for the countdown timer
package countdown_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
  localparam int ONES_MAX = 9;
  localparam int TENS_MAX = 5;
  localparam int MIN_TENS_MAX_DEF = 5;
endpackage

// File: rtl/bcd_down_digit.sv
// bcd_down_digit: one BCD down-counting digit that wraps to MOD-1 and borrows from the next digit
module bcd_down_digit #(
  parameter int MOD = 10,
  parameter int BITS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            ld,
  input  logic [BITS-1:0] ld_val,
  output logic [BITS-1:0] digit,
  output logic            borrow_out
);
  assign borrow_out = en && digit == '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) digit <= '0;
    else if (ld) digit <= ld_val;
    else if (en) digit <= digit == '0 ? BITS'(MOD - 1) : digit - 1'b1;
endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: MM:SS BCD countdown with load clamping, pause/resume and a done pulse at 00:00
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int MIN_TENS_MAX = MIN_TENS_MAX_DEF,
  parameter int BITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              load,
  input  logic [4*BITS-1:0] load_bcd,
  input  logic              start,
  input  logic              pause,
  output logic [4*BITS-1:0] count_bcd,
  output logic              running,
  output logic              done,
  output logic              expired
);
  localparam logic [4*BITS-1:0] ONE_SEC = {{(4*BITS-1){1'b0}}, 1'b1};
  state_t state, state_nxt;
  logic go, wrap, ld, count_zero;
  logic [3:0] en, bor;
  assign count_zero = count_bcd == '0;
  assign go = state == RUN && tick && !pause;
  // a borrow out of the top digit means 00:00 would wrap; reload zero instead
  assign wrap = bor[3];
  assign ld = (load && state != RUN) || wrap;
  assign en = {bor[2:0], go};
  genvar g;
  for (g = 0; g < 4; g++) begin : dig
    localparam int MOD = g == 3 ? MIN_TENS_MAX + 1 : g == 1 ? TENS_MAX + 1 : ONES_MAX + 1;
    logic [BITS-1:0] in_d, clamp_d;
    assign in_d = load_bcd[g*BITS +: BITS];
    assign clamp_d = wrap ? '0 : in_d > BITS'(MOD - 1) ? BITS'(MOD - 1) : in_d;
    bcd_down_digit #(.MOD(MOD), .BITS(BITS)) u_digit (
      .clk(clk),
      .rst(rst),
      .en(en[g]),
      .ld(ld),
      .ld_val(clamp_d),
      .digit(count_bcd[g*BITS +: BITS]),
      .borrow_out(bor[g])
    );
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      done <= 1'b0;
    end else begin
      state <= state_nxt;
      done <= state == RUN && state_nxt == DONE;
    end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  state_nxt = load ? IDLE : start && !count_zero ? RUN : IDLE;
      RUN:   state_nxt = pause ? PAUSE : go && count_bcd == ONE_SEC ? DONE : RUN;
      PAUSE: state_nxt = load ? IDLE : start && !pause ? RUN : PAUSE;
      DONE:  state_nxt = load ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    running = state == RUN;
    expired = state == DONE;
  end
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: scoreboard bench for countdown_timer, one task per scenario
module tb_countdown_timer;
  logic clk = 0, rst = 1, tick = 0, load = 0, start = 0, pause = 0;
  logic [15:0] load_bcd = '0, count_bcd;
  logic running, done, expired;
  logic [18:0] q[$];
  logic [18:0] e, got;
  int total = 0, bad = 0, done_cnt = 0;
  typedef struct {logic t, l, s, p; logic [15:0] v; logic [18:0] e;} stim_t;
  countdown_timer dut (
    .clk(clk), .rst(rst), .tick(tick), .load(load), .load_bcd(load_bcd),
    .start(start), .pause(pause), .count_bcd(count_bcd), .running(running),
    .done(done), .expired(expired)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (done === 1'b1) done_cnt++;
  function automatic stim_t mk(logic t, l, s, p, logic [15:0] v, logic [15:0] c, logic [2:0] f);
    stim_t r;
    r.t = t; r.l = l; r.s = s; r.p = p; r.v = v; r.e = {c, f};
    return r;
  endfunction
  task automatic cyc(input stim_t s);
    tick = s.t; load = s.l; start = s.s; pause = s.p; load_bcd = s.v;
    @(posedge clk); #1;
    tick = 0; load = 0; start = 0; pause = 0;
  endtask
  task automatic test_reset();
    #1 rst = 0;
    #1 q.push_back('0);
    got = {count_bcd, running, done, expired}; e = q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL reset_async got=%h exp=%h", got, e); end
    @(posedge clk); #1 q.push_back('0);
    got = {count_bcd, running, done, expired}; e = q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL reset_held got=%h exp=%h", got, e); end
    @(negedge clk) rst = 1;
  endtask
  task automatic test_min_borrow();
    stim_t s[$];
    s.push_back(mk(0,1,0,0,16'h0100,16'h0100,3'b000));
    s.push_back(mk(0,0,1,0,16'h0,16'h0100,3'b100));
    s.push_back(mk(1,0,0,0,16'h0,16'h0059,3'b100));
    s.push_back(mk(0,0,0,1,16'h0,16'h0059,3'b000));
    foreach (s[i]) begin
      q.push_back(s[i].e); cyc(s[i]);
      got = {count_bcd, running, done, expired}; e = q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL min_borrow[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask
  task automatic test_three_borrow();
    stim_t s[$];
    s.push_back(mk(0,1,0,0,16'h1000,16'h1000,3'b000));
    s.push_back(mk(0,0,1,0,16'h0,16'h1000,3'b100));
    s.push_back(mk(1,0,0,0,16'h0,16'h0959,3'b100));
    s.push_back(mk(0,0,0,1,16'h0,16'h0959,3'b000));
    foreach (s[i]) begin
      q.push_back(s[i].e); cyc(s[i]);
      got = {count_bcd, running, done, expired}; e = q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL three_borrow[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask
  task automatic test_expire();
    stim_t s[$];
    s.push_back(mk(0,1,0,0,16'h0002,16'h0002,3'b000));
    s.push_back(mk(0,0,1,0,16'h0,16'h0002,3'b100));
    s.push_back(mk(1,0,0,0,16'h0,16'h0001,3'b100));
    s.push_back(mk(1,0,0,0,16'h0,16'h0000,3'b011));
    s.push_back(mk(0,0,0,0,16'h0,16'h0000,3'b001));
    s.push_back(mk(1,0,0,0,16'h0,16'h0000,3'b001));
    s.push_back(mk(0,0,1,0,16'h0,16'h0000,3'b001));
    s.push_back(mk(1,0,0,1,16'h0,16'h0000,3'b001));
    s.push_back(mk(0,1,0,0,16'h0000,16'h0000,3'b000));
    s.push_back(mk(0,0,1,0,16'h0,16'h0000,3'b000));
    foreach (s[i]) begin
      q.push_back(s[i].e); cyc(s[i]);
      got = {count_bcd, running, done, expired}; e = q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL expire[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask
  task automatic test_pause();
    stim_t s[$];
    s.push_back(mk(0,1,0,0,16'h0030,16'h0030,3'b000));
    s.push_back(mk(0,0,1,0,16'h0,16'h0030,3'b100));
    s.push_back(mk(1,0,0,1,16'h0,16'h0030,3'b000));
    for (int k = 0; k < 5; k++) s.push_back(mk(1,0,0,0,16'h0,16'h0030,3'b000));
    s.push_back(mk(0,0,1,1,16'h0,16'h0030,3'b000));
    s.push_back(mk(0,0,1,0,16'h0,16'h0030,3'b100));
    s.push_back(mk(1,0,0,0,16'h0,16'h0029,3'b100));
    s.push_back(mk(0,1,1,0,16'h4444,16'h0029,3'b100));
    s.push_back(mk(0,0,0,1,16'h0,16'h0029,3'b000));
    foreach (s[i]) begin
      q.push_back(s[i].e); cyc(s[i]);
      got = {count_bcd, running, done, expired}; e = q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL pause[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask
  task automatic test_clamp();
    stim_t s[$];
    s.push_back(mk(0,1,0,0,16'h7A99,16'h5959,3'b000));
    s.push_back(mk(0,1,0,0,16'h3B8C,16'h3959,3'b000));
    s.push_back(mk(1,0,0,0,16'h0,16'h3959,3'b000));
    foreach (s[i]) begin
      q.push_back(s[i].e); cyc(s[i]);
      got = {count_bcd, running, done, expired}; e = q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL clamp[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask
  task automatic test_back_to_back();
    stim_t s[$];
    s.push_back(mk(0,0,1,0,16'h0,16'h3959,3'b100));
    s.push_back(mk(1,0,0,0,16'h0,16'h3958,3'b100));
    s.push_back(mk(1,0,0,0,16'h0,16'h3957,3'b100));
    s.push_back(mk(0,0,0,1,16'h0,16'h3957,3'b000));
    s.push_back(mk(0,1,0,0,16'h0010,16'h0010,3'b000));
    s.push_back(mk(0,0,1,0,16'h0,16'h0010,3'b100));
    s.push_back(mk(1,0,0,0,16'h0,16'h0009,3'b100));
    s.push_back(mk(0,0,0,1,16'h0,16'h0009,3'b000));
    foreach (s[i]) begin
      q.push_back(s[i].e); cyc(s[i]);
      got = {count_bcd, running, done, expired}; e = q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL back_to_back[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask
  task automatic test_async_abort();
    stim_t s[$];
    s.push_back(mk(0,1,0,0,16'h1234,16'h1234,3'b000));
    s.push_back(mk(0,0,1,0,16'h0,16'h1234,3'b100));
    foreach (s[i]) begin
      q.push_back(s[i].e); cyc(s[i]);
      got = {count_bcd, running, done, expired}; e = q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL abort_setup[%0d] got=%h exp=%h", i, got, e); end
    end
    #3 rst = 0;
    #1 q.push_back('0);
    got = {count_bcd, running, done, expired}; e = q.pop_front(); total++;
    if (got !== e) begin bad++; $display("FAIL abort_async got=%h exp=%h", got, e); end
    repeat (2) begin
      @(posedge clk); #1 q.push_back('0);
      got = {count_bcd, running, done, expired}; e = q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL abort_held got=%h exp=%h", got, e); end
    end
    @(negedge clk) rst = 1;
    s.delete();
    s.push_back(mk(0,0,1,0,16'h0,16'h0000,3'b000));
    s.push_back(mk(0,1,0,0,16'h0005,16'h0005,3'b000));
    s.push_back(mk(0,0,1,0,16'h0,16'h0005,3'b100));
    foreach (s[i]) begin
      q.push_back(s[i].e); cyc(s[i]);
      got = {count_bcd, running, done, expired}; e = q.pop_front(); total++;
      if (got !== e) begin bad++; $display("FAIL after_reset[%0d] got=%h exp=%h", i, got, e); end
    end
  endtask
  initial begin
    test_reset();
    test_min_borrow();
    test_three_borrow();
    test_expire();
    test_pause();
    test_clamp();
    test_back_to_back();
    test_async_abort();
    total++;
    if (done_cnt !== 1) begin bad++; $display("FAIL done_pulses got=%0d exp=1", done_cnt); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 Parameter MIN_TENS_MAX, default 5: maximum legal minutes-tens digit.
REQ-002 Parameter BITS, default 4: width of each BCD digit.
REQ-003 clk  input  1: single clock; all state changes on posedge clk.
REQ-004 rst  input  1: reset, asynchronous, active-low.
REQ-005 tick  input  1: count-enable pulse, one clk cycle wide, once per second.
REQ-006 load  input  1: load load_bcd into the count.
REQ-007 load_bcd  input  4*BITS: {min_tens, min_ones, sec_tens, sec_ones}, BCD.
REQ-008 start  input  1: begin or resume counting down.
REQ-009 pause  input  1: suspend counting.
REQ-010 count_bcd  output  4*BITS: current MM:SS value, same digit order as load_bcd, registered.
REQ-011 running  output  1: high while in RUN.
REQ-012 done  output  1: one-cycle pulse on reaching 00:00 from RUN.
REQ-013 expired  output  1: high while in DONE.

Function
REQ-014 FSM states: IDLE, RUN, PAUSE, DONE.
REQ-015 IDLE: load -> count <= clamped load_bcd, stay IDLE; start with count != 0000 -> RUN; start with count == 0000 ignored.
REQ-016 RUN: tick without pause -> count decrements by one second on the same edge; pause -> PAUSE, no decrement that cycle (pause beats tick).
REQ-017 RUN: load and start ignored.
REQ-018 PAUSE: ticks ignored, count held; start without pause -> RUN; load -> clamped load_bcd, -> IDLE.
REQ-019 PAUSE: pause and start in the same cycle -> stay PAUSE (pause wins).
REQ-020 DONE: count held at 0000; ticks, start, pause ignored; load -> clamped load_bcd, -> IDLE.
REQ-021 Decrement is a cascaded BCD borrow chain: sec_ones 0->9 borrows; sec_tens 0->5 borrows; min_ones 0->9 borrows; min_tens decrements.
REQ-022 The borrow chain never wraps 00:00 to 59:59; decrement is only possible while count != 0000.
REQ-023 A tick taking the count from 00:01 to 00:00 moves the FSM to DONE and asserts done on the same edge for exactly one cycle.
REQ-024 Load clamp applies per digit: an illegal digit is replaced by its maximum (min_tens -> MIN_TENS_MAX, min_ones -> 9, sec_tens -> 5, sec_ones -> 9); legal digits pass through unchanged.
REQ-025 Count latency: count_bcd reflects a tick or load on the posedge that samples it; no extra pipeline stage.
REQ-026 running = (state == RUN) and expired = (state == DONE), both decoded from registered state.

Reset
REQ-027 When rst is low, outputs take these values immediately, regardless of clk: state IDLE, count_bcd 0000, running 0, done 0, expired 0.
REQ-028 Reset asserted mid-RUN aborts the countdown; no done pulse is generated.
REQ-029 After rst deasserts, operation restarts from IDLE; the first load or start is accepted on the next posedge.

Structure
REQ-030 Shared package countdown_pkg holds the FSM state encoding and the digit maximum constants (9, 5, MIN_TENS_MAX).
REQ-031 Sub-module bcd_down_digit (parameter MOD) is instantiated four times.
REQ-032 bcd_down_digit inputs: clk, rst, en (borrow-in), ld, ld_val.
REQ-033 bcd_down_digit outputs: digit, borrow_out; borrow_out = en && digit == 0, combinational.
REQ-034 Top level holds the FSM, load clamping, and done/expired logic.

Verification
REQ-035 Load 01:00, start, one tick -> 00:59; running = 1.
REQ-036 Load 10:00, start, one tick -> 09:59 (three-level borrow).
REQ-037 Load 00:02, start, two ticks -> 00:00; done high exactly one cycle; expired = 1; a further tick leaves count 00:00.
REQ-038 RUN at 00:30, pause and tick in the same cycle -> 00:30 held, PAUSE; five more ticks -> still 00:30; start then tick -> 00:29.
REQ-039 load_bcd = {7, A, 9, 9} in IDLE -> count 59:59.
REQ-040 RUN at 12:34, rst pulled low between clk edges -> count 0000 and running 0 before the next edge; done never asserted.
